multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Multicycle FSM that steps the single-issue RV64 datapath through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
//  Drives the per-state enables the decoder's static fields cannot express alone:
//   - IR load and PC write
//   - RF and data-memory write enables
//   - mux selects and ALU op
//  Handshakes with instruction and data memory; bounds memory waits with a timeout.
// PARAMETERS
//  WORDSIZE          64  datapath width; sets perf-counter width
//  INSTRUCTION_SIZE  32  instruction width
//  MEM_TIMEOUT       16  max cycles a req may wait for ack before bus error (>=1)
// PORTS
//  clk               in   1   rising-edge clock
//  reset             in   1   synchronous, active-high
//  instruction       in   32  current IR contents (valid from DECODE on)
//  alu_zero          in   1   ALU result == 0
//  imem_req / imem_ack   out / in   1   fetch handshake
//  dmem_req / dmem_ack   out / in   1   data-memory handshake
//  ir_load           out  1   capture instruction into IR
//  pc_write          out  1   update PC
//  pc_src            out  1   0=PC+4, 1=branch target
//  rf_write_en       out  1   register-file write
//  dm_write_en       out  1   data-memory write (only with dmem_req)
//  mux_0_sel         out  1   ALU A: 0=rf_a (1=PC reserved, never driven)
//  mux_1_sel         out  1   ALU B: 0=rf_b, 1=immediate
//  mux_2_sel         out  1   RF write data: 0=ALU, 1=dmem read data
//  alu_operation     out  3   ALU op code
//  state             out  3   current FSM state, debug
//  illegal, bus_error  out  1   sticky fault flags
//  instr_retired     out  1   1-cycle pulse per completed instruction
// BEHAVIOUR
//  Reset and defaults
//   - reset (sync, dominates all) -> state=FETCH, all outputs 0, timeout counter 0, pending req dropped.
//   - Outputs are Moore (registered state); handshake-qualified pulses are combinational on ack.
//  FETCH
//   - imem_req=1 until imem_ack.
//   - On ack: ir_load=1 that cycle -> DECODE. Ack without req is ignored.
//  DECODE (1 cycle), by opcode:
//   - 0110011 R / 0010011 I-ALU -> EXECUTE.
//   - 0000011 load / 0100011 store -> EXECUTE.
//   - 1100011 branch, funct3 000 beq / 001 bne -> EXECUTE.
//   - Anything else -> HALT, illegal=1.
//  ALU map (funct3 / funct7[5]):
//   - 000/0 ADD, 000/1 SUB (R only).
//   - 111 AND, 110 OR, 100 XOR.
//   - Other funct3 -> HALT, illegal=1.
//  EXECUTE
//   - R: mux_1_sel=0. I/load/store: mux_1_sel=1, alu_operation=ADD.
//   - R/I -> WRITEBACK; load/store -> MEMORY.
//   - Branch: alu_operation=SUB, pc_write=1, pc_src = (beq ? alu_zero : !alu_zero), instr_retired=1 -> FETCH.
//  MEMORY
//   - dmem_req=1; store also dm_write_en=1; held stable until dmem_ack.
//   - Store ack: pc_write=1, pc_src=0, instr_retired=1 -> FETCH.
//   - Load ack -> WRITEBACK.
//  WRITEBACK (1 cycle)
//   - rf_write_en=1, mux_2_sel = (load ? 1 : 0), pc_write=1, pc_src=0, instr_retired=1 -> FETCH.
//  HALT
//   - All enables/reqs 0; flags hold until reset.
//  Timeout
//   - Counter clears on entering FETCH/MEMORY and increments each cycle the req is unacked.
//   - At MEM_TIMEOUT -> HALT, bus_error=1.
//   - Ack in the same cycle the counter hits MEM_TIMEOUT: ack wins, no error.
//  Latency (zero-wait memory): branch 3, R/I 4, store 4, load 5 cycles.
//  Encoding: state FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=7.
// CONFIGURATION
//  SEQ_PERF_COUNTERS_EN defined:
//   - Adds outputs cycle_count and retired_count [WORDSIZE-1:0].
//   - cycle_count +1 every non-reset cycle; retired_count +1 on instr_retired.
//   - Both wrap modulo 2^WORDSIZE, reset to 0, freeze in HALT.
//  Undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Shared include riscv_defs.vh: opcode constants, ALU op codes (ADD=000 SUB=001 AND=010 OR=011 XOR=100), state encodings.
//  One sub-module: seq_timeout_counter (clear/enable/expired, width $clog2(MEM_TIMEOUT+1)).
// TESTING
//  ADD x3,x1,x2 (0x002081B3), acks same cycle:
//   - states 0,1,2,4,0; rf_write_en=1 only in WB.
//   - mux_2_sel=0; instr_retired once; 4 cycles.
//  LD x3,107(x7) (0x06B3B183), dmem_ack after 2 waits:
//   - dmem_req high 3 cycles, dm_write_en=0.
//   - WB mux_2_sel=1; 7 cycles total.
//  beq with alu_zero=1 -> EXECUTE pc_write=1, pc_src=1. bne with alu_zero=1 -> pc_src=0.
//  imem_ack withheld 16 cycles -> HALT, bus_error=1. Ack arriving on cycle 16 -> no error.
//  Opcode 0x7F -> DECODE then HALT, illegal=1, all enables 0 until reset.
//  Reset asserted in MEMORY during a store wait:
//   - next edge state=0, dmem_req=0, dm_write_en=0; fetch resumes after deassert.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multicycle sequencer: opcodes, ALU op codes, FSM state
// encodings, instruction classes and the decode helper.
package multicycle_sequencer_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    K_R, K_I, K_LOAD, K_STORE, K_BEQ, K_BNE
  } kind_e;

  typedef struct packed {
    logic    legal;
    kind_e   kind;
    alu_op_e op;
  } decode_t;

  // Classifies an instruction and picks its ALU op; SUB exists only for R-type.
  function automatic decode_t decode_fields(input logic [6:0] opcode,
                                            input logic [2:0] funct3,
                                            input logic       funct7_b5);
    decode_t d;
    d.legal = 1'b0;
    d.kind  = K_R;
    d.op    = ALU_ADD;
    case (opcode)
      OP_R, OP_I: begin
        d.kind  = (opcode == OP_R) ? K_R : K_I;
        d.legal = 1'b1;
        case (funct3)
          3'b000:  d.op = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b111:  d.op = ALU_AND;
          3'b110:  d.op = ALU_OR;
          3'b100:  d.op = ALU_XOR;
          default: d.legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        d.kind  = K_LOAD;
        d.legal = 1'b1;
      end
      OP_STORE: begin
        d.kind  = K_STORE;
        d.legal = 1'b1;
      end
      OP_BRANCH: begin
        d.op = ALU_SUB;
        if (funct3 == 3'b000) begin
          d.kind  = K_BEQ;
          d.legal = 1'b1;
        end else if (funct3 == 3'b001) begin
          d.kind  = K_BNE;
          d.legal = 1'b1;
        end
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_timeout.sv
// Memory-wait timeout counter: counts unacknowledged request cycles and flags the
// cycle in which the count would reach MEM_TIMEOUT.
module seq_timeout_counter
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);
  localparam logic [W-1:0] LAST  = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && count_reg != LIMIT) begin
      count_reg <= count_reg + W'(1);
    end
  end

  // An ack in the same cycle drops enable, so the ack wins over expiry.
  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for a single-issue RV64 datapath.
// Optional build macro SEQ_PERF_COUNTERS_EN adds cycle_count / retired_count outputs.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned WORDSIZE         = 64,
  parameter int unsigned INSTRUCTION_SIZE = 32,
  parameter int unsigned MEM_TIMEOUT      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [INSTRUCTION_SIZE-1:0] instruction,
  input  logic                        alu_zero,
  output logic                        imem_req,
  input  logic                        imem_ack,
  output logic                        dmem_req,
  input  logic                        dmem_ack,
  output logic                        ir_load,
  output logic                        pc_write,
  output logic                        pc_src,
  output logic                        rf_write_en,
  output logic                        dm_write_en,
  output logic                        mux_0_sel,
  output logic                        mux_1_sel,
  output logic                        mux_2_sel,
  output logic [2:0]                  alu_operation,
  output logic [2:0]                  state,
  output logic                        illegal,
  output logic                        bus_error,
  output logic                        instr_retired
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [WORDSIZE-1:0]         cycle_count,
  output logic [WORDSIZE-1:0]         retired_count
`endif
);

  state_e  state_reg;
  kind_e   kind_reg;
  alu_op_e op_reg;
  logic    illegal_reg;
  logic    bus_error_reg;

  decode_t dec;
  logic    imem_take, dmem_take;
  logic    is_store, is_branch, exec_branch, store_done, in_wb;
  logic    wait_enable, wait_clear, expired;
  logic    unused_instr_bits;

  assign dec = decode_fields(instruction[6:0], instruction[14:12], instruction[30]);
  assign unused_instr_bits = ^{instruction[INSTRUCTION_SIZE-1:31], instruction[29:15],
                               instruction[11:7]};

  // Requests are dropped while reset is held so no transaction is left pending.
  assign imem_req  = (state_reg == S_FETCH) && !reset;
  assign dmem_req  = (state_reg == S_MEMORY) && !reset;
  assign imem_take = imem_req && imem_ack;
  assign dmem_take = dmem_req && dmem_ack;

  assign is_store    = (kind_reg == K_STORE);
  assign is_branch   = (kind_reg == K_BEQ) || (kind_reg == K_BNE);
  assign exec_branch = (state_reg == S_EXECUTE) && is_branch;
  assign store_done  = dmem_take && is_store;
  assign in_wb       = (state_reg == S_WRITEBACK);

  assign ir_load       = imem_take;
  assign dm_write_en   = dmem_req && is_store;
  assign pc_write      = exec_branch || store_done || in_wb;
  assign instr_retired = exec_branch || store_done || in_wb;
  assign pc_src        = exec_branch && ((kind_reg == K_BEQ) ? alu_zero : !alu_zero);
  assign rf_write_en   = in_wb;
  assign mux_0_sel     = 1'b0;
  assign mux_1_sel     = (state_reg == S_EXECUTE) &&
                         (kind_reg == K_I || kind_reg == K_LOAD || kind_reg == K_STORE);
  assign mux_2_sel     = in_wb && (kind_reg == K_LOAD);
  assign alu_operation = (state_reg == S_EXECUTE) ? op_reg : ALU_ADD;
  assign state         = state_reg;
  assign illegal       = illegal_reg;
  assign bus_error     = bus_error_reg;

  // Counter is held at zero outside the wait states and on every accepted ack.
  assign wait_enable = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
  assign wait_clear  = !(state_reg == S_FETCH || state_reg == S_MEMORY) ||
                       imem_take || dmem_take;

  seq_timeout_counter #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (wait_clear),
    .enable (wait_enable),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_FETCH;
      kind_reg      <= K_R;
      op_reg        <= ALU_ADD;
      illegal_reg   <= 1'b0;
      bus_error_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (imem_ack) begin
            state_reg <= S_DECODE;
          end else if (expired) begin
            state_reg     <= S_HALT;
            bus_error_reg <= 1'b1;
          end
        end
        S_DECODE: begin
          kind_reg <= dec.kind;
          op_reg   <= dec.op;
          if (dec.legal) begin
            state_reg <= S_EXECUTE;
          end else begin
            state_reg   <= S_HALT;
            illegal_reg <= 1'b1;
          end
        end
        S_EXECUTE: begin
          case (kind_reg)
            K_R, K_I:         state_reg <= S_WRITEBACK;
            K_LOAD, K_STORE:  state_reg <= S_MEMORY;
            default:          state_reg <= S_FETCH;
          endcase
        end
        S_MEMORY: begin
          if (dmem_ack) begin
            state_reg <= is_store ? S_FETCH : S_WRITEBACK;
          end else if (expired) begin
            state_reg     <= S_HALT;
            bus_error_reg <= 1'b1;
          end
        end
        S_WRITEBACK: state_reg <= S_FETCH;
        S_HALT:      state_reg <= S_HALT;
        default:     state_reg <= S_HALT;
      endcase
    end
  end

`ifdef SEQ_PERF_COUNTERS_EN
  logic [WORDSIZE-1:0] cycle_count_reg;
  logic [WORDSIZE-1:0] retired_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_reg   <= '0;
      retired_count_reg <= '0;
    end else if (state_reg != S_HALT) begin
      cycle_count_reg <= cycle_count_reg + WORDSIZE'(1);
      if (instr_retired) begin
        retired_count_reg <= retired_count_reg + WORDSIZE'(1);
      end
    end
  end

  assign cycle_count   = cycle_count_reg;
  assign retired_count = retired_count_reg;
`else
  logic unused_cfg;
  assign unused_cfg = (WORDSIZE != 0);
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: one linear sequence of instructions and
// memory-handshake scenarios, each observed output checked against hand-derived values.
module tb_multicycle_sequencer;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ORI  = 32'h00006013;
  localparam logic [31:0] I_LD   = 32'h06B3B183;
  localparam logic [31:0] I_SD   = 32'h00003023;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_BNE  = 32'h00001063;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_SLL  = 32'h002091B3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        alu_zero, imem_ack, dmem_ack;
  logic        imem_req, dmem_req, ir_load, pc_write, pc_src, rf_write_en, dm_write_en;
  logic        mux_0_sel, mux_1_sel, mux_2_sel, illegal, bus_error, instr_retired;
  logic [2:0]  alu_operation, state;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int retire_cnt = 0;
  int dreq_cnt   = 0;
  int cyc_cnt    = 0;
  int r0, d0, c0;

  multicycle_sequencer dut (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_zero(alu_zero),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src), .rf_write_en(rf_write_en),
    .dm_write_en(dm_write_en), .mux_0_sel(mux_0_sel), .mux_1_sel(mux_1_sel),
    .mux_2_sel(mux_2_sel), .alu_operation(alu_operation), .state(state),
    .illegal(illegal), .bus_error(bus_error), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (instr_retired) retire_cnt <= retire_cnt + 1;
    if (dmem_req) dreq_cnt <= dreq_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] instr);
    instruction = instr;
    imem_ack = 1'b1;
    #1;
    chk("fetch_state", 32'(state), 0);
    chk("fetch_ir_load", 32'(ir_load), 1);
    tick();
    imem_ack = 1'b0;
  endtask

  function automatic logic [31:0] enables();
    return 32'({imem_req, dmem_req, ir_load, pc_write, rf_write_en, dm_write_en, instr_retired});
  endfunction

  initial begin
    reset = 1'b1; instruction = '0; alu_zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) tick();
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_enables", enables(), 0);
    chk("rst_flags", 32'({illegal, bus_error}), 0);
    reset = 1'b0;

    // ADD x3,x1,x2 with same-cycle ack: 0,1,2,4,0
    r0 = retire_cnt; c0 = cyc_cnt;
    fetch(I_ADD);
    #1 chk("add_decode", 32'({state, rf_write_en}), 32'({3'd1, 1'b0}));
    tick(); #1 chk("add_exec", 32'({state, rf_write_en, mux_1_sel, alu_operation}), 32'({3'd2, 1'b0, 1'b0, 3'd0}));
    tick(); #1 chk("add_wb", 32'({state, rf_write_en, mux_2_sel, pc_write, pc_src, instr_retired}), 32'({3'd4, 5'b10101}));
    tick(); #1 chk("add_back", 32'(state), 0);
    chk("add_retired", 32'(retire_cnt - r0), 1);
    chk("add_cycles", 32'(cyc_cnt - c0), 4);

    // LD x3,107(x7) with two wait cycles
    r0 = retire_cnt; c0 = cyc_cnt; d0 = dreq_cnt;
    fetch(I_LD);
    tick(); #1 chk("ld_exec", 32'({state, mux_1_sel, alu_operation}), 32'({3'd2, 1'b1, 3'd0}));
    tick(); #1 chk("ld_mem_wait", 32'({state, dmem_req, dm_write_en}), 32'({3'd3, 2'b10}));
    tick(); dmem_ack = 1'b0;
    tick(); dmem_ack = 1'b1; #1 chk("ld_mem_ack", 32'({state, dmem_req, pc_write}), 32'({3'd3, 2'b10}));
    tick(); dmem_ack = 1'b0;
    #1 chk("ld_wb", 32'({state, rf_write_en, mux_2_sel, instr_retired}), 32'({3'd4, 3'b111}));
    tick(); #1 chk("ld_back", 32'(state), 0);
    chk("ld_dmem_req_cycles", 32'(dreq_cnt - d0), 3);
    chk("ld_cycles", 32'(cyc_cnt - c0), 7);
    chk("ld_retired", 32'(retire_cnt - r0), 1);

    // BEQ taken, BNE not taken (alu_zero=1 for both)
    fetch(I_BEQ);
    tick(); alu_zero = 1'b1;
    #1 chk("beq_exec", 32'({state, pc_write, pc_src, instr_retired, mux_1_sel, alu_operation}), 32'({3'd2, 4'b1110, 3'd1}));
    tick(); alu_zero = 1'b0; #1 chk("beq_back", 32'(state), 0);
    fetch(I_BNE);
    tick(); alu_zero = 1'b1;
    #1 chk("bne_exec", 32'({state, pc_write, pc_src, instr_retired}), 32'({3'd2, 3'b101}));
    alu_zero = 1'b0;
    #1 chk("bne_exec_nz", 32'(pc_src), 1);
    tick(); #1 chk("bne_back", 32'(state), 0);

    // Store with zero-wait data memory
    r0 = retire_cnt;
    fetch(I_SD);
    tick(); #1 chk("sd_exec", 32'({state, mux_1_sel, alu_operation}), 32'({3'd2, 1'b1, 3'd0}));
    tick(); dmem_ack = 1'b1;
    #1 chk("sd_mem", 32'({state, dmem_req, dm_write_en, pc_write, pc_src, instr_retired, rf_write_en}), 32'({3'd3, 6'b111010}));
    tick(); dmem_ack = 1'b0; #1 chk("sd_back", 32'(state), 0);
    chk("sd_retired", 32'(retire_cnt - r0), 1);

    // SUB and ORI ALU ops
    fetch(I_SUB);
    tick(); #1 chk("sub_exec", 32'({mux_1_sel, alu_operation}), 32'({1'b0, 3'd1}));
    tick(); tick();
    fetch(I_ORI);
    tick(); #1 chk("ori_exec", 32'({mux_1_sel, alu_operation}), 32'({1'b1, 3'd3}));
    tick(); #1 chk("ori_wb", 32'({state, rf_write_en}), 32'({3'd4, 1'b1}));
    tick();

    // Fetch ack arrives on the 16th request cycle: no error
    instruction = I_ADD; imem_ack = 1'b0;
    repeat (15) tick();
    imem_ack = 1'b1;
    #1 chk("ack16_ir_load", 32'({state, ir_load}), 32'({3'd0, 1'b1}));
    tick(); imem_ack = 1'b0;
    #1 chk("ack16_no_err", 32'({state, bus_error}), 32'({3'd1, 1'b0}));
    tick(); tick(); tick();

    // Fetch ack withheld 16 cycles: bus error
    repeat (15) tick();
    #1 chk("to_cycle16", 32'({state, bus_error}), 32'({3'd0, 1'b0}));
    tick(); #1 chk("to_halt", 32'({state, bus_error, illegal}), 32'({3'd7, 2'b10}));
    chk("to_enables", enables(), 0);

    reset = 1'b1; tick(); reset = 1'b0;
    #1 chk("rst_clear_flags", 32'({state, bus_error, illegal}), 32'({3'd0, 2'b00}));

    // Illegal opcode 0x7F: DECODE then HALT, stray acks ignored
    fetch(I_BAD);
    #1 chk("bad_decode", 32'(state), 1);
    tick(); #1 chk("bad_halt", 32'({state, illegal, bus_error}), 32'({3'd7, 2'b10}));
    imem_ack = 1'b1; dmem_ack = 1'b1;
    tick(); tick(); #1 chk("bad_hold", 32'({state, illegal}), 32'({3'd7, 1'b1}));
    chk("bad_enables", enables(), 0);
    imem_ack = 1'b0; dmem_ack = 1'b0;

    reset = 1'b1; tick(); reset = 1'b0;
    // Unsupported R funct3 (SLL) is illegal
    fetch(I_SLL);
    tick(); #1 chk("sll_halt", 32'({state, illegal}), 32'({3'd7, 1'b1}));

    // Reset during a store wait in MEMORY
    reset = 1'b1; tick(); reset = 1'b0;
    fetch(I_SD);
    tick(); tick();
    #1 chk("rst_mem_wait", 32'({state, dmem_req, dm_write_en}), 32'({3'd3, 2'b11}));
    tick(); reset = 1'b1;
    tick();
    #1 chk("rst_in_mem", 32'({state, dmem_req, dm_write_en, imem_req}), 32'({3'd0, 3'b000}));
    reset = 1'b0;
    #1 chk("rst_resume_req", 32'(imem_req), 1);
    fetch(I_ADD);
    tick(); tick();
    #1 chk("rst_resume_wb", 32'({state, rf_write_en}), 32'({3'd4, 1'b1}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
